// File: rtl/lsu_iterative.sv
// Multi-cycle logic/shift unit: one logic op or one shift step per clock under a start/busy/done handshake.
// Optional zero/shout flag outputs are built when LSU_FLAGS_EN is defined.
module lsu_iterative #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [3:0]    op,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [CW-1:0] count,
   input  logic          fill,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result
`ifdef LSU_FLAGS_EN
   ,
   output logic          zero,
   output logic          shout
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [CW-1:0] W_CNT = CW'(W);

   state_t        r_state;
   logic [3:0]    r_op;
   logic [W-1:0]  r_b;
   logic          r_fill;
   logic [W-1:0]  r_work;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;
   logic [CW-1:0] w_steps;
   logic [W-1:0]  w_next;
   logic          w_fill;

   // Step count for a new request: logic/transfer take one step, shifts clamp at W.
   always_comb begin
      w_steps = CW'(1);
      if (op[3]) begin
         if (count > W_CNT) begin
            w_steps = W_CNT;
         end else begin
            w_steps = count;
         end
      end else begin
         w_steps = CW'(1);
      end
   end

   // One step of the latched operation applied to the working register.
   always_comb begin
      w_next = r_work;
      w_fill = 1'b0;
      case (r_op[3:2])
         2'b00: w_next = r_work;
         2'b01: begin
            case (r_op[1:0])
               2'b00:   w_next = r_work & r_b;
               2'b01:   w_next = r_work | r_b;
               2'b10:   w_next = r_work ^ r_b;
               default: w_next = ~r_work;
            endcase
         end
         2'b10: begin
            case (r_op[1:0])
               2'b00:   w_fill = 1'b0;
               2'b01:   w_fill = r_work[W-1];
               2'b10:   w_fill = r_work[0];
               default: w_fill = r_fill;
            endcase
            w_next = {w_fill, r_work[W-1:1]};
         end
         default: begin
            case (r_op[1:0])
               2'b10:   w_fill = r_work[W-1];
               2'b11:   w_fill = r_fill;
               default: w_fill = 1'b0;
            endcase
            w_next = {r_work[W-2:0], w_fill};
         end
      endcase
   end

`ifdef LSU_FLAGS_EN
   logic r_zero;
   logic r_shout;
   logic w_out;

   // Bit leaving the word on the current step; only shifts push a bit out.
   always_comb begin
      w_out = 1'b0;
      case (r_op[3:2])
         2'b10:   w_out = r_work[0];
         2'b11:   w_out = r_work[W-1];
         default: w_out = 1'b0;
      endcase
   end
`endif

   // Handshake FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= 4'b0000;
         r_b     <= '0;
         r_fill  <= 1'b0;
         r_work  <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef LSU_FLAGS_EN
         r_zero  <= 1'b0;
         r_shout <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_b    <= b;
                  r_fill <= fill;
                  r_work <= a;
                  r_cnt  <= w_steps;
                  r_busy <= 1'b1;
                  if (w_steps == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
`ifdef LSU_FLAGS_EN
                     r_zero  <= (a == '0);
                     r_shout <= 1'b0;
`endif
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_work <= w_next;
               r_cnt  <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
`ifdef LSU_FLAGS_EN
                  r_zero  <= (w_next == '0);
                  r_shout <= w_out;
`endif
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_work;
`ifdef LSU_FLAGS_EN
   assign zero   = r_zero;
   assign shout  = r_shout;
`endif

endmodule
